// File: rtl/cpu_axi_pkg.sv
// Shared constants for the AXI read-side bridge: IDs, request encodings,
// AR state encoding and the fixed AR attribute fields.
package cpu_axi_pkg;

    // Default AXI IDs for the two read requesters
    localparam logic [3:0] ID_I_DEF = 4'd0;
    localparam logic [3:0] ID_D_DEF = 4'd1;

    // Icache request type that asks for a full 16-byte line (four words)
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    // AR channel state encoding
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    // Requester encoding used for last_grant
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Fixed AR attribute fields: INCR bursts, normal access, no cache hints
    localparam logic [1:0] AR_BURST_INCR = 2'b01;
    localparam logic [1:0] AR_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AR_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AR_PROT_NONE  = 3'b000;

    // Word size in AXI arsize encoding
    localparam logic [2:0] AR_SIZE_WORD = 3'd2;

    // Burst length (beats minus one) for an Icache request
    function automatic logic [7:0] icache_arlen(input logic [2:0] rd_type);
        return (rd_type == RD_TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the Icache, bit 1 the data port.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import cpu_axi_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant; a tie goes to whoever was not granted last
    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11) begin
            grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between the Icache refill port and the
// data read port. One AR in flight at a time, at most one outstanding read
// per requester, R beats steered back by rid.
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] ID_I = ID_I_DEF,
    parameter logic [3:0] ID_D = ID_D_DEF
) (
    input  logic        clk,
    input  logic        reset,

    // Icache refill port
    input  logic        icache_rd_req,
    input  logic [2:0]  icache_rd_type,
    input  logic [31:0] icache_rd_addr,
    output logic        icache_rd_rdy,
    output logic        icache_ret_valid,
    output logic        icache_ret_last,
    output logic [31:0] icache_ret_data,

    // Data read port
    input  logic        data_rd_req,
    input  logic [1:0]  data_rd_size,
    input  logic [31:0] data_rd_addr,
    output logic        data_rd_addr_ok,
    output logic        data_rd_data_ok,
    output logic [31:0] data_rd_rdata,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    logic [0:0]  state_q, state_d;
    logic        busy_i_q, busy_i_d;
    logic        busy_d_q, busy_d_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;

    logic [1:0]  eligible;
    logic [1:0]  arb_grant;
    logic        grant_i;
    logic        grant_d;
    logic        beat_i;
    logic        beat_d;

    // A requester may only be granted when it has nothing outstanding
    assign eligible = {data_rd_req & ~busy_d_q, icache_rd_req & ~busy_i_q};

    rr_arb2 u_rr_arb2 (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    // Grants are only honoured while the AR channel is free
    assign grant_i = (state_q == AR_IDLE) & arb_grant[0];
    assign grant_d = (state_q == AR_IDLE) & arb_grant[1];

    // R steering: a beat is delivered only to a requester that is waiting
    assign beat_i = rvalid & (rid == ID_I) & busy_i_q;
    assign beat_d = rvalid & (rid == ID_D) & busy_d_q;

    // Request handshakes and R routing outputs
    always_comb begin
        icache_rd_rdy    = grant_i;
        data_rd_addr_ok  = grant_d;
        icache_ret_valid = beat_i;
        icache_ret_last  = beat_i & rlast;
        icache_ret_data  = rdata;
        data_rd_data_ok  = beat_d;
        data_rd_rdata    = rdata;
        rready           = 1'b1;
    end

    // AR channel outputs come straight from the latched payload
    always_comb begin
        arvalid = (state_q == AR_SEND);
        arid    = arid_q;
        araddr  = araddr_q;
        arlen   = arlen_q;
        arsize  = arsize_q;
        arburst = AR_BURST_INCR;
        arlock  = AR_LOCK_NONE;
        arcache = AR_CACHE_NONE;
        arprot  = AR_PROT_NONE;
    end

    // Next-state: AR FSM, payload latch, busy flags and round-robin history
    always_comb begin
        state_d      = state_q;
        busy_i_d     = busy_i_q;
        busy_d_d     = busy_d_q;
        last_grant_d = last_grant_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;

        // Final beat frees the requester; a grant in the same cycle wins below
        if (rvalid && rlast && (rid == ID_I)) begin
            busy_i_d = 1'b0;
        end
        if (rvalid && rlast && (rid == ID_D)) begin
            busy_d_d = 1'b0;
        end

        case (state_q)
            AR_IDLE: begin
                if (grant_i) begin
                    arid_d       = ID_I;
                    araddr_d     = icache_rd_addr;
                    arlen_d      = icache_arlen(icache_rd_type);
                    arsize_d     = AR_SIZE_WORD;
                    busy_i_d     = 1'b1;
                    last_grant_d = REQ_I;
                    state_d      = AR_SEND;
                end else if (grant_d) begin
                    arid_d       = ID_D;
                    araddr_d     = data_rd_addr;
                    arlen_d      = 8'd0;
                    arsize_d     = {1'b0, data_rd_size};
                    busy_d_d     = 1'b1;
                    last_grant_d = REQ_D;
                    state_d      = AR_SEND;
                end
            end
            AR_SEND: begin
                if (arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: begin
                state_d = AR_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to D so the first tie goes to I
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= AR_IDLE;
            busy_i_q     <= 1'b0;
            busy_d_q     <= 1'b0;
            last_grant_q <= REQ_D;
            arid_q       <= 4'd0;
            araddr_q     <= 32'd0;
            arlen_q      <= 8'd0;
            arsize_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            busy_i_q     <= busy_i_d;
            busy_d_q     <= busy_d_d;
            last_grant_q <= last_grant_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter: the bench plays both requesters and
// the AXI slave, predicts grants and routing from a transaction-level model,
// and a separate monitor compares DUT outputs against scoreboard queues.
module tb_axi_rd_arbiter;

    localparam logic [3:0] TID_I = 4'd0;
    localparam logic [3:0] TID_D = 4'd1;
    localparam int NCYC  = 4000;
    localparam int NDRAIN = 300;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          idx;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_rd_req;
    logic [2:0]  icache_rd_type;
    logic [31:0] icache_rd_addr;
    logic        icache_rd_rdy;
    logic        icache_ret_valid;
    logic        icache_ret_last;
    logic [31:0] icache_ret_data;
    logic        data_rd_req;
    logic [1:0]  data_rd_size;
    logic [31:0] data_rd_addr;
    logic        data_rd_addr_ok;
    logic        data_rd_data_ok;
    logic [31:0] data_rd_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ar_t  ar_q[$];
    ret_t ret_i_q[$];
    ret_t ret_d_q[$];

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .ID_I (TID_I),
        .ID_D (TID_D)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .icache_rd_req    (icache_rd_req),
        .icache_rd_type   (icache_rd_type),
        .icache_rd_addr   (icache_rd_addr),
        .icache_rd_rdy    (icache_rd_rdy),
        .icache_ret_valid (icache_ret_valid),
        .icache_ret_last  (icache_ret_last),
        .icache_ret_data  (icache_ret_data),
        .data_rd_req      (data_rd_req),
        .data_rd_size     (data_rd_size),
        .data_rd_addr     (data_rd_addr),
        .data_rd_addr_ok  (data_rd_addr_ok),
        .data_rd_data_ok  (data_rd_data_ok),
        .data_rd_rdata    (data_rd_rdata),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arlock           (arlock),
        .arcache          (arcache),
        .arprot           (arprot),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares AR payloads and returned beats against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (arvalid) begin
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 64'(arvalid), 64'd0);
                end else begin
                    check("ar_payload",
                          64'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
                          64'({ar_q[0].id, ar_q[0].addr, ar_q[0].len, ar_q[0].size,
                               2'b01, 2'b00, 4'b0000, 3'b000}));
                    if (arready) void'(ar_q.pop_front());
                end
            end
            begin
                bit exp_i;
                exp_i = (ret_i_q.size() != 0) && (ret_i_q[0].cyc == cyc);
                if (icache_ret_valid || exp_i) begin
                    check("icache_ret_valid", 64'(icache_ret_valid), 64'(exp_i));
                    if (exp_i) begin
                        if (icache_ret_valid) begin
                            check("icache_ret_data", 64'(icache_ret_data), 64'(ret_i_q[0].data));
                            check("icache_ret_last", 64'(icache_ret_last), 64'(ret_i_q[0].last));
                        end
                        void'(ret_i_q.pop_front());
                    end
                end
            end
            begin
                bit exp_d;
                exp_d = (ret_d_q.size() != 0) && (ret_d_q[0].cyc == cyc);
                if (data_rd_data_ok || exp_d) begin
                    check("data_rd_data_ok", 64'(data_rd_data_ok), 64'(exp_d));
                    if (exp_d) begin
                        if (data_rd_data_ok) begin
                            check("data_rd_rdata", 64'(data_rd_rdata), 64'(ret_d_q[0].data));
                        end
                        void'(ret_d_q.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus and reference model
    initial begin
        // Reference model state: what each requester has outstanding
        bit   m_busy_i, m_busy_d, m_last_d, m_ar_pend;
        ar_t  m_cur;
        int   pend_beats[2];
        bit   i_req_h, d_req_h;
        logic [2:0]  i_type_h;
        logic [31:0] i_addr_h, d_addr_h;
        logic [1:0]  d_size_h;
        int   stall;
        bit   stop;

        m_busy_i = 0; m_busy_d = 0; m_last_d = 1; m_ar_pend = 0;
        m_cur = '{id: 4'd0, addr: 32'd0, len: 8'd0, size: 3'd0, idx: 0};
        pend_beats[0] = 0; pend_beats[1] = 0;
        i_req_h = 0; d_req_h = 0; i_type_h = 3'd0; i_addr_h = 32'd0;
        d_addr_h = 32'd0; d_size_h = 2'd0; stall = 0; stop = 0;

        reset = 1'b1;
        icache_rd_req = 1'b0; icache_rd_type = 3'd0; icache_rd_addr = 32'd0;
        data_rd_req = 1'b0; data_rd_size = 2'd0; data_rd_addr = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_arvalid", 64'(arvalid), 64'd0);
        check("reset_rd_rdy", 64'(icache_rd_rdy), 64'd0);
        check("reset_addr_ok", 64'(data_rd_addr_ok), 64'd0);
        check("reset_ret_valid", 64'(icache_ret_valid), 64'd0);
        check("reset_data_ok", 64'(data_rd_data_ok), 64'd0);
        check("reset_rready", 64'(rready), 64'd1);

        for (int k = 0; k < NCYC; k++) begin
            bit first;
            bit e_i, e_d, g_i, g_d;
            int r;
            first = (k == 0);
            stop  = (k >= NCYC - NDRAIN);
            @(posedge clk);
            #1;
            cyc++;

            // Requesters: hold a request until the model says it was taken
            if (!i_req_h && !stop && (first || $urandom_range(0, 3) != 0)) begin
                i_req_h  = 1;
                i_type_h = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
                i_addr_h = $urandom & 32'hFFFF_FFF0;
                if (first) begin
                    i_type_h = 3'b100;
                    i_addr_h = 32'h1C00_0000;
                end
            end
            if (!d_req_h && !stop && (first || $urandom_range(0, 2) == 0)) begin
                d_req_h  = 1;
                d_size_h = 2'($urandom_range(0, 2));
                d_addr_h = $urandom;
            end
            icache_rd_req  = i_req_h;
            icache_rd_type = i_req_h ? i_type_h : 3'($urandom_range(0, 7));
            icache_rd_addr = i_req_h ? i_addr_h : $urandom;
            data_rd_req    = d_req_h;
            data_rd_size   = d_req_h ? d_size_h : 2'($urandom_range(0, 3));
            data_rd_addr   = d_req_h ? d_addr_h : $urandom;

            // Slave AR acceptance with occasional long stalls
            if (stall > 0) begin
                arready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 9) == 0) begin
                arready = 1'b0;
                stall = $urandom_range(3, 6);
            end else begin
                arready = 1'($urandom_range(0, 1));
            end

            // Slave R channel: interleave outstanding reads, sometimes a stray beat
            rvalid = 1'b0; rid = 4'($urandom_range(0, 15)); rlast = 1'($urandom_range(0, 1));
            rdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 4 && pend_beats[0] > 0) begin
                pend_beats[0]--;
                rvalid = 1'b1; rid = TID_I; rlast = (pend_beats[0] == 0);
                if (m_busy_i) ret_i_q.push_back('{data: rdata, last: rlast, cyc: cyc});
            end else if (r < 8 && pend_beats[1] > 0) begin
                pend_beats[1]--;
                rvalid = 1'b1; rid = TID_D; rlast = (pend_beats[1] == 0);
                if (m_busy_d) ret_d_q.push_back('{data: rdata, last: rlast, cyc: cyc});
            end else if (r == 8) begin
                rvalid = 1'b1;
                if (!m_busy_d && pend_beats[1] == 0 && !d_req_h) rid = TID_D;
                else if (!m_busy_i && pend_beats[0] == 0 && !i_req_h) rid = TID_I;
                else rid = 4'd7;
            end

            @(negedge clk);
            // Predicted grant: eligible = requesting and nothing outstanding;
            // tie goes to the one not granted last; nothing while an AR waits
            e_i = i_req_h && !m_busy_i;
            e_d = d_req_h && !m_busy_d;
            g_i = 0; g_d = 0;
            if (!m_ar_pend) begin
                if (e_i && e_d) begin
                    g_i = m_last_d;
                    g_d = !m_last_d;
                end else begin
                    g_i = e_i;
                    g_d = e_d;
                end
            end
            check("icache_rd_rdy", 64'(icache_rd_rdy), 64'(g_i));
            check("data_rd_addr_ok", 64'(data_rd_addr_ok), 64'(g_d));
            check("arvalid", 64'(arvalid), 64'(m_ar_pend));
            check("rready", 64'(rready), 64'd1);

            // Model update for the edge that follows
            if (m_ar_pend && arready) begin
                m_ar_pend = 0;
                pend_beats[m_cur.idx] = int'(m_cur.len) + 1;
            end
            if (rvalid && rlast && rid == TID_I) m_busy_i = 0;
            if (rvalid && rlast && rid == TID_D) m_busy_d = 0;
            if (g_i) begin
                m_cur = '{id: TID_I, addr: i_addr_h, len: (i_type_h == 3'b100) ? 8'd3 : 8'd0,
                          size: 3'd2, idx: 0};
                m_busy_i = 1; m_last_d = 0; i_req_h = 0;
            end else if (g_d) begin
                m_cur = '{id: TID_D, addr: d_addr_h, len: 8'd0, size: {1'b0, d_size_h}, idx: 1};
                m_busy_d = 1; m_last_d = 1; d_req_h = 0;
            end
            if (g_i || g_d) begin
                m_ar_pend = 1;
                ar_q.push_back(m_cur);
            end
        end

        // Everything issued must have been seen by the drain point
        check("drain_ar_q", 64'(ar_q.size()), 64'd0);
        check("drain_ret_i_q", 64'(ret_i_q.size()), 64'd0);
        check("drain_ret_d_q", 64'(ret_d_q.size()), 64'd0);
        check("drain_pending", 64'(pend_beats[0] + pend_beats[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read-address/read-data channel pair between the instruction cache refill port and the data-side read port. Sits between the Icache miss interface and the data sram-like interface on one side and the AXI master read channels on the other, in front of the bridge's write-path logic. Arbitrates requests round-robin, issues one AR transaction at a time, keeps at most one read outstanding per requester, and routes R beats back by `rid`.

## Interface
Parameters:
- `ID_I`, 4'd0, AXI ID for Icache refills
- `ID_D`, 4'd1, AXI ID for data reads

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `icache_rd_req`  in  1  Icache read request, held until accepted
- `icache_rd_type`  in  3  3'b100 = 16-byte line; any other value = single word
- `icache_rd_addr`  in  32  refill address
- `icache_rd_rdy`  out  1  request accepted this cycle
- `icache_ret_valid`  out  1  refill beat valid
- `icache_ret_last`  out  1  final refill beat
- `icache_ret_data`  out  32  refill beat data
- `data_rd_req`  in  1  data read request
- `data_rd_size`  in  2  log2 bytes (0/1/2)
- `data_rd_addr`  in  32  data read address
- `data_rd_addr_ok`  out  1  request accepted this cycle
- `data_rd_data_ok`  out  1  read data returned
- `data_rd_rdata`  out  32  read data
- `arid`/`araddr`/`arlen`/`arsize`  out  4/32/8/3  AR payload
- `arburst`/`arlock`/`arcache`/`arprot`  out  2/2/4/3  constants 2'b01/0/0/0
- `arvalid`  out  1;  `arready`  in  1
- `rid`  in  4;  `rdata`  in  32;  `rlast`  in  1;  `rvalid`  in  1;  `rready`  out  1

## Operation
- AR FSM states: `AR_IDLE`, `AR_SEND`.
- `AR_IDLE`: a requester is eligible iff its req=1 and its busy flag=0. If exactly one is eligible, grant it. If both are eligible, grant the one not equal to `last_grant`. Assert that requester's `rd_rdy`/`addr_ok` combinationally for exactly one cycle. Latch the AR payload, set its busy flag, update `last_grant`, and go to `AR_SEND`.
- Payload for I: `arid=ID_I`, `arsize=3'd2`, `arlen=8'd3` if type==3'b100, else 8'd0.
- Payload for D: `arid=ID_D`, `arsize={1'b0,data_rd_size}`, `arlen=8'd0`.
- `AR_SEND`: `arvalid=1` with a stable payload. On `arready`, return to `AR_IDLE`. No grant is made in `AR_SEND`.
- `rready` is constant 1. Both requesters accept data every cycle.
- R routing:
  - `rvalid & rid==ID_I & busy_i`: `icache_ret_valid=1`, `ret_last=rlast`, `ret_data=rdata`.
  - `rvalid & rid==ID_D & busy_d`: `data_rd_data_ok=1`, `rdata` passed through.
  - A beat whose ID has no busy flag set is consumed and dropped.
- A busy flag clears on `rvalid & rlast` for its ID.
- The write channels are out of scope.

## Timing
- Reset values: state `AR_IDLE`, `arvalid=0`, AR payload regs 0, `busy_i=busy_d=0`, `last_grant=D`. This makes I win the first tie.
- Outputs after reset: `rd_rdy=addr_ok=0`, `ret_valid=data_ok=0`, `rready=1`.
- Accept in cycle N puts `arvalid=1` in N+1. The earliest next accept is the cycle after the `arready` handshake.
- Busy flags are registered. An rlast for I in cycle N lets I be granted again no earlier than N+1.
- The R path is combinational, with zero added latency.
- The I and D busy flags are independent. D can be granted while an I refill is still returning beats; the I refill and the D read proceed concurrently, and the slave may interleave them by ID.
- Reset asserted mid-transaction: all state is dropped at the next edge. The AXI slave is reset with the core, so no stale R beats are expected.

## Structure
- Shared package `cpu_axi_pkg` holds:
  - `ID_I`/`ID_D` defaults
  - `RD_TYPE_LINE=3'b100`
  - AR state enum
  - the AXI constant fields
- One natural sub-module: `rr_arb2`, a 2-way round-robin picker. Inputs: `eligible[1:0]`, `last_grant`. Outputs: one-hot grant.

## Test plan
- Single I line refill at 0x1C000000: accepted in cycle 1 → `arvalid` in cycle 2 with `arid=0`, `arlen=3`, `arsize=2`. Four R beats → four `ret_valid`, `ret_last` only on beat 4, `busy_i` clears after beat 4.
- Simultaneous I and D requests out of reset → I granted first. D is granted in the first `AR_IDLE` cycle after I's `arready`, with `arid=1`, `arlen=0`, `arsize={0,size}`.
- Repeated simultaneous requests with both flags clear → grants alternate I, D, I, D.
- D request while an I refill is mid-burst → D AR issued. Interleaved R beats (rid 0, 1, 0) route correctly, and `data_rd_data_ok` pulses once.
- `arready` held low for 5 cycles → `arvalid` and payload stable for all 5 cycles, and no further `rd_rdy`/`addr_ok`.
- Re-request from I in the same cycle as its rlast → not accepted that cycle, accepted the next. Separately, a stray R beat with `rid=1` while D is idle → dropped, with no `data_ok`.
